exe_redirect_ctrl: RTL
======================

# exe_redirect_ctrl

Pipeline controller for SCHOLAR RISC-V. It consumes the `exe2ctrl_t` payload from EXE, owns the fetch program counter and resolves taken jumps and branches into redirects. It also detects load-use and CSR read-after-write hazards and drives the stall and flush controls of the IF, ID and EXE stages. It sits between EXE and the IF/ID pipeline registers.

## Interface
- `RESET_ADDR`, default `32'h0000_0000`: fetch PC loaded at reset.
- `ADDR_WIDTH` / `DATA_WIDTH` / `RF_ADDR_WIDTH` / `CSR_ADDR_WIDTH`: taken from `core_pkg` (32/32/5/12).

Ports (clock and reset first):
- `clk_i` in 1: core clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `exe_valid_i` in 1: EXE holds a valid instruction.
- `exe2ctrl_i` in `exe2ctrl_t`: pc, rd, csr_waddr, exe_out, op3, pc_ctrl, csr_ctrl.
- `exe_is_load_i` in 1: instruction in EXE is a load.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_rs1_i`, `id_rs2_i` in 5: ID source registers.
- `id_rs1_used_i`, `id_rs2_used_i` in 1: source is read.
- `id_csr_raddr_i` in 12: CSR read by ID.
- `id_csr_read_i` in 1: ID reads a CSR.
- `imem_ready_i` in 1: instruction memory accepts `pc_o`.
- `pc_o` out ADDR: fetch address.
- `pc_valid_o` out 1: fetch request valid.
- `stall_if_o`, `stall_id_o` out 1: hold the IF/ID and ID/EXE registers.
- `flush_id_o`, `flush_exe_o` out 1: turn the stage into a bubble.
- `misalign_o` out 1: one-cycle pulse, redirect target bit 1 set.

## Operation
- `pc_ctrl` encodings (`core_pkg`):
  - `PC_INC`: no redirect.
  - `PC_JAL`: target = pc + op3.
  - `PC_JALR`: target = exe_out with bit 0 cleared.
  - `PC_BRANCH`: target = pc + op3 when exe_out[0] = 1; otherwise no redirect.
- Arithmetic: modulo 2^ADDR_WIDTH and wraps silently. pc_o + 4 at `32'hFFFF_FFFC` yields 0.
- Taken = `exe_valid_i` and a redirecting `pc_ctrl`. Taken is evaluated only in RUN and HOLD.
- Target bit 1 set: `misalign_o` pulses and bits [1:0] are cleared. The redirect still occurs.
- Load-use: `exe_valid_i & exe_is_load_i & rd!=0 & id_valid_i` and (rs1 used and rs1==rd, or rs2 used and rs2==rd).
- CSR hazard: `exe_valid_i & csr_ctrl!=CSR_IDLE & id_valid_i & id_csr_read_i & id_csr_raddr_i==csr_waddr`.
- Priority: taken > load-use > CSR hazard.
- FSM states:
  - BOOT: `pc_valid_o`=0 for one cycle after reset, then RUN.
  - RUN: on taken, load `pc_o` with the target, assert `flush_id_o` and `flush_exe_o` this cycle, then go to REDIRECT. On load-use, assert `stall_if_o`, `stall_id_o` and `flush_exe_o` for one cycle and hold `pc_o`. On CSR hazard, apply the same stall pattern and go to HOLD. Otherwise `pc_o` += 4 when `imem_ready_i`.
  - REDIRECT: `pc_valid_o`=1 at the target. Hazards and `exe_valid_i` are ignored because EXE is a bubble. Leave to RUN on the `imem_ready_i` cycle, with `pc_o` += 4.
  - HOLD: stalls plus `flush_exe_o` stay asserted while the CSR hazard persists. Leave to RUN when the hazard clears. A taken op in HOLD behaves as in RUN.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight redirects are dropped.

## Timing
- Reset values:
  - `pc_o`=RESET_ADDR.
  - `pc_valid_o`=0.
  - All stall, flush and `misalign_o` outputs = 0.
  - FSM=BOOT.
- Flush, stall and `misalign_o` are combinational from the current inputs and state.
- `pc_o` is registered; the target is visible the cycle after the taken op.
- Redirect penalty: 2 bubbles (ID and EXE), plus one extra cycle per cycle `imem_ready_i` is low in REDIRECT.
- Load-use penalty: exactly 1 cycle.
- `imem_ready_i` low in RUN: `pc_o` holds and no flush occurs.

## Configuration
- `EXE_REDIRECT_PERF_EN` defined: adds outputs `redirect_cnt_o` [31:0] and `stall_cnt_o` [31:0].
  - `redirect_cnt_o` increments on each taken cycle.
  - `stall_cnt_o` increments on each cycle `stall_id_o`=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent and there is no other behavioural change.

## Test plan
- Reset release, `imem_ready_i`=1, no EXE ops: cycle 1 `pc_valid_o`=0; then `pc_o` = 0x0, 0x4, 0x8 on successive cycles.
- `PC_JAL` with pc=0x100, op3=0x20: `flush_id_o` and `flush_exe_o` = 1 in that cycle; next cycle `pc_o`=0x120 with `pc_valid_o`=1. With `imem_ready_i` held low for 3 cycles, `pc_o` stays 0x120, then advances to 0x124.
- `PC_BRANCH`: exe_out=0 → no flush and `pc_o` advances by 4. `PC_JALR` with exe_out=0x203 → `pc_o`=0x200 and `misalign_o` pulses.
- Load with rd=5 in EXE, ID rs2=5 used: exactly one cycle of `stall_if_o`, `stall_id_o` and `flush_exe_o` with `pc_o` held. With rd=0, no stall.
- CSR write to 0x300 in EXE for 2 cycles, ID reads 0x300: stall for 2 cycles, then RUN. The same stimulus plus a taken branch in EXE gives a redirect with no stall.
- `rst_i` asserted in REDIRECT: `pc_o`=RESET_ADDR immediately and BOOT behaviour repeats. With `EXE_REDIRECT_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/exe_redirect_ctrl.sv
// SCHOLAR RISC-V EXE redirect/hazard controller: owns fetch PC, stalls and flushes.
// Optional perf counters enabled with `define EXE_REDIRECT_PERF_EN.
package core_pkg;
    localparam int ADDR_WIDTH     = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int RF_ADDR_WIDTH  = 5;
    localparam int CSR_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_JAL    = 2'd1,
        PC_JALR   = 2'd2,
        PC_BRANCH = 2'd3
    } pc_ctrl_t;

    typedef enum logic [1:0] {
        CSR_IDLE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_ctrl_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     pc;
        logic [RF_ADDR_WIDTH-1:0]  rd;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
        logic [DATA_WIDTH-1:0]     exe_out;
        logic [DATA_WIDTH-1:0]     op3;
        pc_ctrl_t                  pc_ctrl;
        csr_ctrl_t                 csr_ctrl;
    } exe2ctrl_t;
endpackage

module exe_redirect_ctrl
    import core_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      exe_valid_i,
    input  exe2ctrl_t                 exe2ctrl_i,
    input  logic                      exe_is_load_i,
    input  logic                      id_valid_i,
    input  logic [RF_ADDR_WIDTH-1:0]  id_rs1_i,
    input  logic [RF_ADDR_WIDTH-1:0]  id_rs2_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [CSR_ADDR_WIDTH-1:0] id_csr_raddr_i,
    input  logic                      id_csr_read_i,
    input  logic                      imem_ready_i,
    output logic [ADDR_WIDTH-1:0]     pc_o,
    output logic                      pc_valid_o,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      flush_id_o,
    output logic                      flush_exe_o,
    output logic                      misalign_o
`ifdef EXE_REDIRECT_PERF_EN
    ,
    output logic [31:0]               redirect_cnt_o,
    output logic [31:0]               stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pc_valid;

    logic                  w_active;
    logic                  w_redir_op;
    logic                  w_taken;
    logic [ADDR_WIDTH-1:0] w_raw_tgt;
    logic [ADDR_WIDTH-1:0] w_tgt;
    logic                  w_rs_hit;
    logic                  w_lu_raw;
    logic                  w_csr_raw;
    logic                  w_lu;
    logic                  w_csr;
    logic                  w_stall;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_active = (r_state == RUN) || (r_state == HOLD);
    assign w_pc_inc = r_pc + ADDR_WIDTH'(4);

    always_comb begin
        w_redir_op = 1'b0;
        w_raw_tgt  = exe2ctrl_i.pc + exe2ctrl_i.op3;
        unique case (exe2ctrl_i.pc_ctrl)
            PC_JAL:    w_redir_op = 1'b1;
            PC_JALR: begin
                w_redir_op = 1'b1;
                w_raw_tgt  = {exe2ctrl_i.exe_out[ADDR_WIDTH-1:1], 1'b0};
            end
            PC_BRANCH: w_redir_op = exe2ctrl_i.exe_out[0];
            default:   w_redir_op = 1'b0;
        endcase
    end

    // A misaligned target is still followed, just forced to a word boundary.
    assign w_tgt = w_raw_tgt[1] ? {w_raw_tgt[ADDR_WIDTH-1:2], 2'b00}
                                : w_raw_tgt;
    assign w_taken = w_active & exe_valid_i & w_redir_op;

    assign w_rs_hit  = (id_rs1_used_i && id_rs1_i == exe2ctrl_i.rd)
                    || (id_rs2_used_i && id_rs2_i == exe2ctrl_i.rd);
    assign w_lu_raw  = exe_valid_i & exe_is_load_i & id_valid_i
                     & (exe2ctrl_i.rd != '0) & w_rs_hit;
    assign w_csr_raw = exe_valid_i & (exe2ctrl_i.csr_ctrl != CSR_IDLE)
                     & id_valid_i & id_csr_read_i
                     & (id_csr_raddr_i == exe2ctrl_i.csr_waddr);

    assign w_lu    = w_active & ~w_taken & w_lu_raw;
    assign w_csr   = w_active & ~w_taken & ~w_lu_raw & w_csr_raw;
    assign w_stall = w_lu | w_csr;

    assign pc_o        = r_pc;
    assign pc_valid_o  = r_pc_valid;
    assign stall_if_o  = w_stall;
    assign stall_id_o  = w_stall;
    assign flush_id_o  = w_taken;
    assign flush_exe_o = w_taken | w_stall;
    assign misalign_o  = w_taken & w_raw_tgt[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= BOOT;
            r_pc       <= RESET_ADDR;
            r_pc_valid <= 1'b0;
        end else begin
            unique case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                REDIRECT: begin
                    if (imem_ready_i) begin
                        r_pc    <= w_pc_inc;
                        r_state <= RUN;
                    end
                end
                default: begin
                    if (w_taken) begin
                        r_pc    <= w_tgt;
                        r_state <= REDIRECT;
                    end else if (w_lu) begin
                        r_state <= RUN;
                    end else if (w_csr) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= RUN;
                        if (imem_ready_i)
                            r_pc <= w_pc_inc;
                    end
                end
            endcase
        end
    end

`ifdef EXE_REDIRECT_PERF_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_taken)
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign redirect_cnt_o = r_redirect_cnt;
    assign stall_cnt_o    = r_stall_cnt;
`endif

endmodule
